// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the peripheral/RAM responder.
//   mem_resp_state_t : responder FSM encoding
//   MEM_LAT_MAX      : largest supported response latency
//   MEM_BE_LEGAL     : byte-enable patterns accepted on a 32-bit bus
//   be_legal()       : membership test against MEM_BE_LEGAL
package mem_responder_pkg;

  typedef enum logic [1:0] {MR_IDLE, MR_WAIT, MR_RESP} mem_resp_state_t;

  localparam int MEM_LAT_MAX = 4;

  // Byte, naturally aligned halfword, full word.
  localparam int MEM_BE_NUM = 7;
  localparam logic [MEM_BE_NUM-1:0][3:0] MEM_BE_LEGAL = {
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < MEM_BE_NUM; i++)
      if (be == MEM_BE_LEGAL[i]) ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/mem_responder_sram.sv
// mem_sram_be: single-port word array with per-byte write enables.
// Read data is registered on the same enabled edge that performs a write
// (read-first), which matches the usual vendor block-RAM primitive.
//   clk      : clock
//   i_en     : port enable (read and/or write this edge)
//   i_we     : per-byte write enables
//   i_addr   : word index
//   i_wdata  : write data
//   o_rdata  : registered read data
module mem_sram_be #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [XLEN/8-1:0] i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic [XLEN-1:0]   o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH_WORDS];
  logic [XLEN-1:0] r_rdata;

  // No reset: array and output register map onto block RAM.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < XLEN/8; b++)
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: target side of the core's peripheral/RAM bus.
// Decodes one address window, serves byte-enabled reads/writes from an
// internal array, and answers a fixed LATENCY enabled cycles after accept.
//   clk, rst    : clock, async active-high reset
//   clk_en      : global enable; all state frozen while low
//   mem_addr    : byte address (word aligned)
//   mem_byteen  : byte lane enables (little-endian lanes)
//   mem_we      : 1 = write, 0 = read
//   mem_req     : request strobe
//   mem_wdata   : write data
//   mem_rdata   : read data, valid with mem_rvalid
//   mem_err     : access fault, valid with mem_rvalid
//   mem_rvalid  : one enabled-cycle response strobe
//   mem_busy    : request in flight, new requests ignored
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = 'h1000_0000,
  parameter int              LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN/8-1:0] mem_byteen,
  input  logic              mem_we,
  input  logic              mem_req,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_err,
  output logic              mem_rvalid,
  output logic              mem_busy
);

  localparam int NB    = XLEN/8;
  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MEM_LAT_MAX);
  localparam logic [XLEN:0] WIN_BYTES = (XLEN+1)'(4*DEPTH_WORDS);

  // ---------------- decode (one extra bit so the window end cannot wrap)
  logic [XLEN:0]   w_addr_x, w_base_x, w_end_x, w_off;
  logic [AW-1:0]   w_index;
  logic            w_hit, w_be_ok, w_fault, w_accept;
  logic [NB-1:0]   w_sram_we;
  logic [XLEN-1:0] w_sram_q, w_lane_mask, w_resp_rdata;

  assign w_addr_x = {1'b0, mem_addr};
  assign w_base_x = {1'b0, BASE_ADDR};
  assign w_end_x  = w_base_x + WIN_BYTES;
  assign w_hit    = (w_addr_x >= w_base_x) && (w_addr_x < w_end_x);
  assign w_off    = w_addr_x - w_base_x;
  assign w_index  = AW'(w_off >> 2);

  if (XLEN == 32) begin : g_be32
    assign w_be_ok = be_legal(mem_byteen);
  end else begin : g_be_wide
    // Sub-word patterns are only defined for a 4-lane bus.
    assign w_be_ok = &mem_byteen;
  end

  assign w_fault = !w_hit || (mem_addr[1:0] != 2'b00) || !w_be_ok;

  // ---------------- FSM state and per-request attributes
  mem_resp_state_t  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rvalid, r_busy;
  logic             r_we, r_fault;
  logic [NB-1:0]    r_be;
  logic [XLEN-1:0]  r_rdata_hold;
  logic             r_err_hold;

  assign w_accept  = mem_req && clk_en && (r_state != MR_WAIT);
  // Faulting writes never touch the array.
  assign w_sram_we = (w_accept && mem_we && !w_fault) ? mem_byteen : '0;

  mem_sram_be #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_sram (
    .clk     (clk),
    .i_en    (w_accept),
    .i_we    (w_sram_we),
    .i_addr  (w_index),
    .i_wdata (mem_wdata),
    .o_rdata (w_sram_q)
  );

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign w_lane_mask[8*b +: 8] = {8{r_be[b]}};
  end

  // Array output only changes on accept, so it is stable for the whole
  // response (including clk_en-stalled RESP cycles).
  assign w_resp_rdata = (r_fault || r_we) ? '0 : (w_sram_q & w_lane_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= MR_IDLE;
      r_cnt        <= '0;
      r_rvalid     <= 1'b0;
      r_busy       <= 1'b0;
      r_we         <= 1'b0;
      r_fault      <= 1'b0;
      r_be         <= '0;
      r_rdata_hold <= '0;
      r_err_hold   <= 1'b0;
    end else if (clk_en) begin
      // Capture the response as it leaves RESP so outputs hold afterwards.
      if (r_state == MR_RESP) begin
        r_rdata_hold <= w_resp_rdata;
        r_err_hold   <= r_fault;
      end
      if (w_accept) begin
        r_we    <= mem_we;
        r_fault <= w_fault;
        r_be    <= mem_byteen;
        if (LATENCY == 1) begin
          r_state  <= MR_RESP;
          r_rvalid <= 1'b1;
          r_busy   <= 1'b0;
        end else begin
          r_state  <= MR_WAIT;
          r_cnt    <= CNT_W'(LATENCY - 2);
          r_rvalid <= 1'b0;
          r_busy   <= 1'b1;
        end
      end else begin
        case (r_state)
          MR_WAIT: begin
            if (r_cnt == '0) begin
              r_state  <= MR_RESP;
              r_rvalid <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          MR_RESP: begin
            r_state  <= MR_IDLE;
            r_rvalid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_rvalid = r_rvalid;
  assign mem_busy   = r_busy;
  assign mem_rdata  = r_rvalid ? w_resp_rdata : r_rdata_hold;
  assign mem_err    = r_rvalid ? r_fault      : r_err_hold;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance at LATENCY=1 (index 0) and one at
// LATENCY=3 (index 1). Stimulus pushes expected responses (data, err and
// the enabled-cycle count at which rvalid must appear) into per-instance
// queues; a negedge monitor pops and compares on every enabled rvalid.
module tb_mem_responder;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  logic        clk, rst, clk_en;
  logic [31:0] addr [2];
  logic [3:0]  be   [2];
  logic        we   [2];
  logic        req  [2];
  logic [31:0] wd   [2];
  logic [31:0] rd   [2];
  logic        err  [2];
  logic        rv   [2];
  logic        busy [2];

  exp_t q0[$], q1[$];
  int   n_vec = 0, n_bad = 0;
  int   ecnt  = 0;

  mem_responder #(.LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .mem_addr(addr[0]), .mem_byteen(be[0]), .mem_we(we[0]), .mem_req(req[0]),
    .mem_wdata(wd[0]), .mem_rdata(rd[0]), .mem_err(err[0]),
    .mem_rvalid(rv[0]), .mem_busy(busy[0])
  );

  mem_responder #(.LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .mem_addr(addr[1]), .mem_byteen(be[1]), .mem_we(we[1]), .mem_req(req[1]),
    .mem_wdata(wd[1]), .mem_rdata(rd[1]), .mem_err(err[1]),
    .mem_rvalid(rv[1]), .mem_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enabled-edge counter used to time responses.
  always @(posedge clk) if (clk_en) ecnt <= ecnt + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk(input int d);
    exp_t e;
    logic found;
    found = 1'b0;
    if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); found = 1'b1; end
    if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); found = 1'b1; end
    n_vec++;
    if (!found) begin
      n_bad++;
      $display("FAIL resp%0d: unexpected rvalid rdata=%h err=%b at cyc %0d", d, rd[d], err[d], ecnt);
    end else if (rd[d] !== e.d || err[d] !== e.e || ecnt != e.c) begin
      n_bad++;
      $display("FAIL resp%0d: got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
               d, rd[d], err[d], ecnt, e.d, e.e, e.c);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && clk_en) begin
      if (rv[0]) chk(0);
      if (rv[1]) chk(1);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One-cycle request; if acc, the response is expected LAT-1 enabled
  // edges after the accept edge.
  task automatic issue(input int d, input logic [31:0] a, input logic [3:0] b,
                       input logic w, input logic [31:0] wdat,
                       input logic [31:0] ed, input logic ee, input bit acc);
    exp_t e;
    addr[d] = a; be[d] = b; we[d] = w; wd[d] = wdat; req[d] = 1'b1;
    @(posedge clk); #1;
    req[d] = 1'b0;
    if (acc) begin
      e.d = ed; e.e = ee;
      e.c = ecnt + ((d == 0) ? LAT0 : LAT1) - 1;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; be[i] = '0; we[i] = 1'b0; req[i] = 1'b0; wd[i] = '0;
    end
    step(); step();
    cmp("rst0_out", {rd[0], 3'(0)} | 35'({err[0], rv[0], busy[0]}), '0);
    cmp("rst1_out", {rd[1], 3'(0)} | 35'({err[1], rv[1], busy[1]}), '0);
    rst = 1'b0;
    step();

    // ---- LATENCY=1: back-to-back, each accepted in the previous RESP
    issue(0, 32'h1000_0010, 4'b1111, 1, 32'hDEADBEEF, 32'h0,        0, 1);
    issue(0, 32'h1000_0010, 4'b1111, 0, 32'h0,        32'hDEADBEEF, 0, 1);
    issue(0, 32'h1000_0010, 4'b0010, 1, 32'h0000_5500, 32'h0,       0, 1);
    issue(0, 32'h1000_0010, 4'b1111, 0, 32'h0,        32'hDEAD55EF, 0, 1);
    issue(0, 32'h1000_0010, 4'b1100, 0, 32'h0,        32'hDEAD0000, 0, 1);
    issue(0, 32'h1000_0010, 4'b0011, 0, 32'h0,        32'h000055EF, 0, 1);
    issue(0, 32'h1000_0000, 4'b1111, 1, 32'hA5A5A5A5, 32'h0,        0, 1);
    // faults
    issue(0, 32'h0FFF_FFFC, 4'b1111, 1, 32'h11111111, 32'h0, 1, 1);
    issue(0, 32'h1000_1000, 4'b1111, 1, 32'h22222222, 32'h0, 1, 1);
    issue(0, 32'h1000_0012, 4'b1111, 1, 32'h33333333, 32'h0, 1, 1);
    issue(0, 32'h1000_0010, 4'b0101, 1, 32'h44444444, 32'h0, 1, 1);
    issue(0, 32'h1000_0010, 4'b0000, 0, 32'h0,        32'h0, 1, 1);
    issue(0, 32'h0FFF_FFFC, 4'b1111, 0, 32'h0,        32'h0, 1, 1);
    // array unchanged by the faults
    issue(0, 32'h1000_0000, 4'b1111, 0, 32'h0, 32'hA5A5A5A5, 0, 1);
    issue(0, 32'h1000_0010, 4'b1111, 0, 32'h0, 32'hDEAD55EF, 0, 1);
    issue(0, 32'h1000_0010, 4'b1000, 1, 32'h7700_0000, 32'h0, 0, 1);
    issue(0, 32'h1000_0FFC, 4'b1111, 1, 32'h0BADF00D, 32'h0, 0, 1);
    issue(0, 32'h1000_0010, 4'b1111, 0, 32'h0, 32'h77AD55EF, 0, 1);
    issue(0, 32'h1000_0FFC, 4'b1111, 0, 32'h0, 32'h0BADF00D, 0, 1);
    repeat (3) step();

    // ---- LATENCY=3: busy window, ignored request, accept on RESP
    issue(1, 32'h1000_0010, 4'b1111, 1, 32'hCAFEF00D, 32'h0, 0, 1);
    cmp("busy_w0", 32'(busy[1]), 1);
    issue(1, 32'h1000_0010, 4'b1111, 0, 32'h0, 32'h0, 0, 0);   // ignored
    cmp("busy_w1", 32'(busy[1]), 1);
    step();
    cmp("busy_resp", 32'(busy[1]), 0);
    cmp("rv_resp", 32'(rv[1]), 1);
    issue(1, 32'h1000_0010, 4'b1111, 0, 32'h0, 32'hCAFEF00D, 0, 1);
    step(); step();
    issue(1, 32'h1000_0010, 4'b0001, 0, 32'h0, 32'h0000000D, 0, 1);
    repeat (4) step();

    // ---- clk_en stalls in WAIT and RESP
    issue(1, 32'h1000_0010, 4'b1100, 0, 32'h0, 32'hCAFE0000, 0, 1);
    clk_en = 1'b0; step();
    clk_en = 1'b1; step();
    cmp("rv_slip", 32'(rv[1]), 0);
    step();
    cmp("rv_at_resp", 32'(rv[1]), 1);
    clk_en = 1'b0; step();
    cmp("rv_hold1", 32'(rv[1]), 1);
    step();
    cmp("rv_hold2", 32'(rv[1]), 1);
    cmp("rd_hold2", rd[1], 32'hCAFE0000);
    clk_en = 1'b1; step();
    cmp("rv_drop", 32'(rv[1]), 0);
    cmp("rd_after", rd[1], 32'hCAFE0000);
    repeat (2) step();

    // ---- async reset mid-WAIT
    issue(1, 32'h1000_0020, 4'b1111, 1, 32'h12345678, 32'h0, 0, 1);
    repeat (3) step();
    issue(1, 32'h1000_0020, 4'b1111, 0, 32'h0, 32'h12345678, 0, 1);
    repeat (3) step();
    cmp("hold_pre_rst", rd[1], 32'h12345678);
    issue(1, 32'h1000_0020, 4'b1111, 0, 32'h0, 32'h0, 0, 0);   // dropped by reset
    cmp("busy_pre_rst", 32'(busy[1]), 1);
    #2 rst = 1'b1;
    #1;
    cmp("rst_mid_out", {rd[1], 3'(0)} | 35'({err[1], rv[1], busy[1]}), '0);
    step(); step();
    rst = 1'b0;
    repeat (6) step();
    issue(1, 32'h1000_0020, 4'b1111, 0, 32'h0, 32'h12345678, 0, 1);
    repeat (4) step();

    for (int i = 0; i < 30 && (q0.size() + q1.size()) > 0; i++) step();
    cmp("drain", 32'(q0.size() + q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
